// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect, and the IF/ID stream.
// With FETCH_PERF_EN defined it also carries the perf_fetched / perf_stall counters.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, misalign_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_stall
`endif
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, misalign_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_stall
`endif
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, in-order request/response queue, redirect flush with wrong-path drain.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters on the interface.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;
  localparam ptr_t FULL = ptr_t'(DEPTH);
  localparam ptr_t ONE  = ptr_t'(1);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  ptr_t        head_q, tail_q, fill_q, discard_q;
  logic        misalign_q;
  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];

  ptr_t        alloc_cnt, unfilled_cnt, drain_base, discard_d;
  logic        head_filled, redir, pop, req_fire, resp_fill;
  logic [31:0] redir_pc;

  // Entries [head, fill) hold instructions, [fill, tail) await their response.
  assign alloc_cnt    = tail_q - head_q;
  assign unfilled_cnt = tail_q - fill_q;
  assign head_filled  = (fill_q != head_q);
  assign redir        = bus.redirect_valid;
  assign redir_pc     = {bus.redirect_pc[31:2], 2'b00};

  assign bus.out_valid    = head_filled & ~redir;
  assign bus.out_inst     = inst_mem_q[head_q[PW-1:0]];
  assign bus.out_pc       = pc_mem_q[head_q[PW-1:0]];
  assign bus.misalign_err = misalign_q;
  assign pop              = bus.out_valid & bus.out_ready;

  // A pop frees the head slot this cycle, so a full queue may still allocate.
  assign bus.imem_req_valid = (state_q == FETCH) & ~redir & ((alloc_cnt < FULL) | pop);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign resp_fill          = (state_q == FETCH) & bus.imem_resp_valid & (unfilled_cnt != '0);

  // Responses still owed by memory after a redirect; one arriving now is already consumed.
  always_comb begin
    drain_base = unfilled_cnt + ((state_q == DRAIN) ? discard_q : '0);
    discard_d  = drain_base;
    if (bus.imem_resp_valid && (drain_base != '0)) discard_d = drain_base - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      discard_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (redir && (bus.redirect_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
      unique case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (redir) pc_q <= redir_pc;
        end
        FETCH, DRAIN: begin
          if (redir) begin
            pc_q      <= redir_pc;
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            discard_q <= discard_d;
            state_q   <= (discard_d != '0) ? DRAIN : FETCH;
          end else if (state_q == FETCH) begin
            if (req_fire) begin
              pc_mem_q[tail_q[PW-1:0]] <= pc_q;
              tail_q <= tail_q + ONE;
              pc_q   <= pc_q + 32'd4;
            end
            if (resp_fill) begin
              inst_mem_q[fill_q[PW-1:0]] <= bus.imem_resp_data;
              fill_q <= fill_q + ONE;
            end
            if (pop) head_q <= head_q + ONE;
          end else if (bus.imem_resp_valid && (discard_q != '0)) begin
            discard_q <= discard_q - ONE;
            if (discard_q == ONE) state_q <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // A response with nothing waiting for it means the memory broke the protocol.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    ((state_q == FETCH) && bus.imem_resp_valid) |-> (unfilled_cnt != '0));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (head_filled && !bus.out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with programmable latency and an
// expected-instruction scoreboard filled as responses are driven, drained as IF/ID pops.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          errors = 0, checks = 0, cyc = 0, lat = 1, last_stale_cyc = -1;
  logic [31:0] exp_pc, cur_addr;
  bit          cur_stale;
  logic        s_req_valid, s_acc, s_out_valid, s_pop, s_misalign, s_redir;
  logic [31:0] s_addr, s_out_pc, s_out_inst;
  int          s_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven at the preceding negedge.
  task automatic tick();
    exp_t  e;
    mreq_t m;
    #2;
    s_cyc       = cyc;
    s_req_valid = bus.imem_req_valid;
    s_addr      = bus.imem_req_addr;
    s_acc       = bus.imem_req_valid & bus.imem_req_ready & ~rst;
    s_out_valid = bus.out_valid;
    s_out_pc    = bus.out_pc;
    s_out_inst  = bus.out_inst;
    s_pop       = bus.out_valid & bus.out_ready & ~rst;
    s_misalign  = bus.misalign_err;
    s_redir     = bus.redirect_valid & ~rst;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      exp_pc = RESET_PC;
    end else begin
      if (bus.imem_resp_valid && (cur_stale || s_redir)) last_stale_cyc = cyc;
      if (s_redir) begin
        chk("redir_out_valid", s_out_valid, 0);
        chk("redir_req_valid", s_req_valid, 0);
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (s_pop) begin
          chk("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_pc", s_out_pc, e.pc);
            chk("out_inst", s_out_inst, e.inst);
          end
        end
        if (bus.imem_resp_valid && !cur_stale) exp_q.push_back('{cur_addr, mem_word(cur_addr)});
        if (s_acc) begin
          chk("req_addr", s_addr, exp_pc);
          mem_q.push_back('{s_addr, cyc + lat, 1'b0});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(m.addr);
      cur_addr  = m.addr;
      cur_stale = m.stale;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      cur_stale = 1'b0;
    end
  endtask

  task automatic wait_acc(input string tag, output logic [31:0] addr, output int c);
    bit got = 1'b0;
    addr = '0;
    c = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (s_acc) begin got = 1'b1; addr = s_addr; c = s_cyc; end
    end
    chk({tag, "_seen"}, got, 1);
  endtask

  task automatic wait_pop(input string tag, output logic [31:0] pc);
    bit got = 1'b0;
    pc = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (s_pop) begin got = 1'b1; pc = s_out_pc; end
    end
    chk({tag, "_seen"}, got, 1);
  endtask

  initial begin
    logic [31:0] a;
    int c, n_acc, first_acc, first_ov, n_pop;
    bit got;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    cur_stale = 1'b0;
    cur_addr = '0;
    exp_pc = RESET_PC;
    @(negedge clk);
    tick();
    tick();
    chk("rst_req_valid", s_req_valid, 0);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_misalign", s_misalign, 0);

    // BOOT, then fetch with IF/ID stalled.
    rst = 1'b0;
    tick();
    chk("boot_req_valid", s_req_valid, 0);
    n_acc = 0; first_acc = -1; first_ov = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_acc) begin n_acc++; if (first_acc < 0) first_acc = s_cyc; end
      if (s_out_valid) begin
        if (first_ov < 0) first_ov = s_cyc;
        chk("stall_out_pc", s_out_pc, RESET_PC);
        chk("stall_out_inst", s_out_inst, mem_word(RESET_PC));
      end
    end
    chk("stall_accepts", n_acc, 2);
    chk("stall_req_valid", s_req_valid, 0);
    chk("first_latency", first_ov - first_acc, 2);

    // Release: one instruction every cycle.
    bus.out_ready = 1'b1;
    n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_pop) n_pop++;
    end
    chk("stream_pops", n_pop, 8);

    // Latency 3, redirect with two requests outstanding.
    lat = 3;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (mem_q.size() == 2 && !bus.imem_resp_valid) got = 1'b1;
    end
    chk("lat3_two_outstanding", got, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick();
    wait_acc("drain_acc", a, c);
    chk("drain_addr", a, 32'h0000_0100);
    chk("drain_before_fetch", c > last_stale_cyc, 1);
    wait_pop("drain_pop", a);
    chk("drain_first_pc", a, 32'h0000_0100);

    // Redirect in a cycle that also has a pop and a response.
    lat = 1;
    for (int i = 0; i < 6; i++) tick();
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (bus.out_valid && bus.imem_resp_valid) got = 1'b1;
      else tick();
    end
    chk("pop_resp_found", got, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    chk("ppr_out_valid", s_out_valid, 0);
    wait_pop("ppr_pop", a);
    chk("ppr_first_pc", a, 32'h0000_0200);

    // Misaligned target.
    chk("pre_misalign", s_misalign, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    wait_acc("mis_acc", a, c);
    chk("mis_addr", a, 32'h0000_0100);
    chk("mis_flag", s_misalign, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mis_sticky", s_misalign, 1);

    // PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    wait_acc("wrap_acc0", a, c);
    chk("wrap_addr0", a, 32'hFFFF_FFF8);
    wait_acc("wrap_acc1", a, c);
    chk("wrap_addr1", a, 32'hFFFF_FFFC);
    wait_acc("wrap_acc2", a, c);
    chk("wrap_addr2", a, 32'h0000_0000);
    chk("wrap_misalign", s_misalign, 1);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_req_valid", s_req_valid, 0);
    chk("mid_rst_out_valid", s_out_valid, 0);
    chk("mid_rst_misalign", s_misalign, 0);
    wait_acc("post_rst_acc", a, c);
    chk("post_rst_addr", a, RESET_PC);
    wait_pop("post_rst_pop", a);
    chk("post_rst_pc", a, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
